// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared types and defaults for the FIR filter chain. The FIR
//               and the decimate-and-buffer stage both use sample_t so that
//               the sample format is defined in exactly one place.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

  // Default sample width, decimation factor and output FIFO depth
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_DECIM      = 4;
  localparam int DEF_FIFO_DEPTH = 8;

  localparam int LOG2_DECIM = $clog2(DEF_DECIM);
  localparam int LVL_W      = $clog2(DEF_FIFO_DEPTH + 1);

  typedef logic signed [DEF_DATA_W-1:0]            sample_t;
  // Wide enough to hold the sum of DECIM full-scale samples without overflow
  typedef logic signed [DEF_DATA_W+LOG2_DECIM-1:0] acc_t;

endpackage
`default_nettype wire

// File: rtl/fir_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fir_sync_fifo
// Description : Single-clock FIFO with a register-array store. A push into a
//               full FIFO is accepted only when a pop happens in the same
//               cycle. Read data is zero whenever the FIFO is empty.
// Ports       : clk, rst            - clock, async active-high reset
//               i_push, i_wdata     - write request and data
//               i_pop               - read request (ignored when empty)
//               o_rdata             - data at head pointer
//               o_full, o_empty     - status flags
//               o_level             - occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = $clog2(DEPTH + 1);

  if ((DEPTH < 2) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fir_sync_fifo: DEPTH must be a power of two in 2..64");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_LW-1:0]  r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == c_LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign w_do_pop  = i_pop && !o_empty;
  // A slot freed by a same-cycle pop makes room for the push
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Gated so the head reads as zero out of reset and whenever empty
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_decim_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fir_decim_buffer
// Description : Boxcar-averages each group of DECIM accepted FIR samples
//               (floor division by a power of two) and queues the averages
//               in an output FIFO drained over valid/ready. Averages that
//               find the FIFO full (with no same-cycle pop) are dropped and
//               flagged on the sticky overflow output.
// Ports       : clk, rst             - clock, async active-high reset
//               in_valid, in_data    - FIR sample stream (no backpressure)
//               out_valid, out_ready - output handshake
//               out_data             - averaged sample at FIFO head
//               level                - FIFO occupancy
//               overflow             - sticky drop indicator
// Revision    : 1.0 - initial release
// ============================================================================
module fir_decim_buffer
  import fir_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DECIM      = DEF_DECIM,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic signed [DATA_W-1:0]        in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [DATA_W-1:0]        out_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
  output logic                            overflow
);

  localparam int c_LOG2_DECIM = $clog2(DECIM);
  localparam int c_ACC_W      = DATA_W + c_LOG2_DECIM;

  if ((DECIM < 2) || (DECIM > 16) || ((DECIM & (DECIM - 1)) != 0)) begin : g_bad_decim
    $error("fir_decim_buffer: DECIM must be a power of two in 2..16");
  end

  logic [c_LOG2_DECIM-1:0]    r_phase;
  logic signed [c_ACC_W-1:0]  r_acc;
  logic                       r_overflow;
  logic signed [c_ACC_W-1:0]  w_base;
  logic signed [c_ACC_W-1:0]  w_in_ext;
  logic signed [c_ACC_W-1:0]  w_sum;
  logic [DATA_W-1:0]          w_avg;
  logic                       w_last;
  logic                       w_pop;
  logic                       w_full;
  logic                       w_empty;
  logic [DATA_W-1:0]          w_rdata;

  always_comb begin
    // Phase 0 starts a fresh group, so the stale accumulator is ignored
    w_base   = (r_phase == '0) ? '0 : r_acc;
    w_in_ext = c_ACC_W'(in_data);
    w_sum    = w_base + w_in_ext;
  end

  // The top DATA_W bits of the sum are exactly sum >>> log2(DECIM),
  // i.e. a floor toward negative infinity
  assign w_avg  = w_sum[c_ACC_W-1:c_LOG2_DECIM];
  assign w_last = in_valid && (r_phase == c_LOG2_DECIM'(DECIM - 1));
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_phase <= '0;
    end else if (in_valid) begin
      if (w_last) begin
        r_acc   <= '0;
        r_phase <= '0;
      end else begin
        r_acc   <= w_sum;
        r_phase <= r_phase + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_last && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  fir_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_last),
    .i_wdata (w_avg),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign out_valid = !w_empty;
  assign out_data  = w_rdata;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_decim_buffer
// Description : Self-checking bench for fir_decim_buffer (DATA_W=16,
//               DECIM=4, FIFO_DEPTH=8). A queue-based model computes each
//               group average by floor division of the group sum and tracks
//               FIFO contents and the sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_decim_buffer;

  localparam int DW    = 16;
  localparam int DEC   = 4;
  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic [LW-1:0]        level;
  logic                 overflow;

  int n_cmp  = 0;
  int n_fail = 0;
  int grp[$];
  int mq[$];
  bit m_ovf;

  fir_decim_buffer #(
    .DATA_W     (DW),
    .DECIM      (DEC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic int floor_div(input int s, input int d);
    int m;
    m = ((s % d) + d) % d;
    return (s - m) / d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [15:0] e;
    e = (mq.size() > 0) ? 16'(mq[0]) : 16'h0000;
    chk({tag, ".valid"},    32'(out_valid), 32'(mq.size() > 0));
    chk({tag, ".data"},     {16'h0, out_data}, {16'h0, e});
    chk({tag, ".level"},    32'(level), 32'(mq.size()));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic cycle(input bit v, input int d, input bit rdy);
    bit full;
    bit had_pop;
    int s;
    @(negedge clk);
    in_valid  = v;
    in_data   = 16'(d);
    out_ready = rdy;
    @(posedge clk);
    #1;
    full    = (mq.size() == DEPTH);
    had_pop = (mq.size() > 0) && rdy;
    if (had_pop) void'(mq.pop_front());
    if (v) begin
      grp.push_back(int'($signed(16'(d))));
      if (grp.size() == DEC) begin
        s = 0;
        foreach (grp[i]) s += grp[i];
        grp.delete();
        if (!full || had_pop) mq.push_back(floor_div(s, DEC));
        else m_ovf = 1'b1;
      end
    end
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    grp.delete();
    mq.delete();
    m_ovf = 1'b0;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Four samples with no consumer, check the known average, then pop it
  task automatic feed_group(input string tag, input int a, input int b,
                            input int c, input int d, input logic [15:0] exp);
    cycle(1'b1, a, 1'b0);
    cycle(1'b1, b, 1'b0);
    cycle(1'b1, c, 1'b0);
    cycle(1'b1, d, 1'b0);
    chk({tag, ".avg"}, {16'h0, out_data}, {16'h0, exp});
    cycle(1'b0, 0, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    do_reset();

    // Basic average and drain
    feed_group("basic", 4, 8, 12, 16, 16'h000A);
    chk("basic.drained_level", 32'(level), 32'd0);
    chk("basic.drained_valid", 32'(out_valid), 32'd0);

    // Floor behaviour and extremes
    feed_group("negfloor", -1, -1, -1, -2, 16'hFFFE);
    feed_group("posfloor", 1, 1, 1, 2, 16'h0001);
    feed_group("maxpos", 32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF, 16'h7FFF);
    feed_group("maxneg", -32768, -32768, -32768, -32768, 16'h8000);
    feed_group("alt", 32'h7FFF, -32768, 32'h7FFF, -32768, 16'hFFFF);

    // Gapped input: output appears only after the 4th sample
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b1, 4 * k, 1'b0);
      if (k < 4) for (int g = 0; g < 3; g++) cycle(1'b0, 0, 1'b0);
    end
    chk("gap.avg", {16'h0, out_data}, 32'h000A);
    chk("gap.level", 32'(level), 32'd1);
    cycle(1'b0, 0, 1'b1);

    // Full FIFO with a 9th group dropped
    do_reset();
    for (int k = 1; k <= 9; k++)
      for (int j = 0; j < DEC; j++) cycle(1'b1, k, 1'b0);
    chk("ovf.level", 32'(level), 32'd8);
    chk("ovf.flag", 32'(overflow), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      chk("ovf.drain", {16'h0, out_data}, 32'(k));
      cycle(1'b0, 0, 1'b1);
    end
    chk("ovf.sticky", 32'(overflow), 32'd1);
    chk("ovf.empty", 32'(level), 32'd0);

    // Full FIFO with a pop in the 9th group's completion cycle
    do_reset();
    for (int k = 1; k <= 8; k++)
      for (int j = 0; j < DEC; j++) cycle(1'b1, k, 1'b0);
    for (int j = 0; j < DEC - 1; j++) cycle(1'b1, 9, 1'b0);
    cycle(1'b1, 9, 1'b1);
    chk("fullpop.level", 32'(level), 32'd8);
    chk("fullpop.flag", 32'(overflow), 32'd0);
    for (int k = 2; k <= 9; k++) begin
      chk("fullpop.drain", {16'h0, out_data}, 32'(k));
      cycle(1'b0, 0, 1'b1);
    end

    // Reset in the middle of a group discards the partial sum
    do_reset();
    cycle(1'b1, 100, 1'b0);
    cycle(1'b1, 100, 1'b0);
    do_reset();
    chk("midrst.level", 32'(level), 32'd0);
    chk("midrst.flag", 32'(overflow), 32'd0);
    feed_group("midrst", 4, 8, 12, 16, 16'h000A);

    // Randomized traffic: slow consumer first to reach full, then faster
    do_reset();
    for (int n = 0; n < 500; n++) begin
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)),
            (n < 250) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_decim_buffer.md
# fir_decim_buffer

Post-filter decimate-and-buffer stage sitting directly downstream of the 21-tap FIR. It consumes one signed FIR output sample per valid cycle and averages each group of DECIM consecutive samples (boxcar, power-of-two divide). Each average is written into a small output FIFO, which is drained by the next stage over a valid/ready handshake. It isolates the free-running filter from a consumer that can stall.

## Interface
- DATA_W, 16: signed sample width, input and output, two's complement.
- DECIM, 4: decimation factor; power of two, 2..16; other values are an elaboration error.
- FIFO_DEPTH, 8: output FIFO entries; power of two, 2..64.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  in_data carries a FIR output sample this cycle.
- in_data  in  DATA_W  signed FIR output sample.
- out_valid  out  1  FIFO non-empty; out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  DATA_W  signed decimated sample at FIFO head.
- level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- overflow  out  1  sticky: a finished average was dropped because the FIFO was full.

## Operation
- No upstream backpressure. Every cycle with in_valid=1 accepts a sample. Cycles with in_valid=0 leave all accumulator state unchanged.
- Accumulator: signed, width DATA_W+log2(DECIM), so it can never overflow. Phase counter: 0..DECIM-1.
- Accepted sample, phase<DECIM-1: acc += in_data (acc = in_data when phase=0); phase++.
- Accepted sample, phase=DECIM-1: result = (acc + in_data) >>> log2(DECIM), an arithmetic shift that floors toward negative infinity. Result is pushed to the FIFO; acc and phase clear to 0.
- The result always fits in DATA_W bits. Take the low DATA_W bits of the shifted value; no saturation logic is needed.
- Push handling:
  - FIFO not full: push is accepted.
  - FIFO full and a pop occurs in the same cycle: push is accepted, level stays at FIFO_DEPTH.
  - FIFO full and no pop: result is dropped, overflow is set to 1. Contents are unchanged.
- A pop occurs when out_valid && out_ready. out_ready while empty has no effect.
- Data leaves the FIFO in strict FIFO order. The read and write pointers wrap modulo FIFO_DEPTH.
- overflow is cleared only by rst.
- Reset values:
  - out_valid=0, out_data=0, level=0, overflow=0.
  - Phase, acc and pointers = 0.
  - Reset mid-group discards the partial sum. Reset with a non-empty FIFO discards all contents.

## Timing
- Push latency: the result from the DECIM-th sample, accepted at edge N, is readable after edge N. If the FIFO was empty, out_valid=1 in the cycle after the sample cycle.
- out_data comes from a register-array read at the head pointer. It is stable while out_valid=1 and out_ready=0.
- level updates on the edge of each push or pop; +1, -1, or unchanged when both occur.
- overflow rises on the edge of the dropping push.
- Maximum sustained throughput is one output per DECIM accepted inputs.
- Simultaneous push and pop when empty is impossible: out_valid=0 when empty.

## Structure
- fir_pkg holds:
  - default DATA_W;
  - typedef sample_t (logic signed [DATA_W-1:0]);
  - typedef acc_t;
  - localparams LOG2_DECIM and LVL_W.
- The FIR block will import the same package for its sample type.
- One sub-module, fir_sync_fifo. It is parameterised by width and depth and provides push, pop, full, empty and level. fir_decim_buffer contains the accumulator, phase counter and overflow logic.

## Test plan
DATA_W=16, DECIM=4, FIFO_DEPTH=8.
- Basic average: reset, then in_valid=1 with 4, 8, 12, 16 on consecutive cycles -> out_valid=1 next cycle, out_data=10, level=1. out_ready=1 -> level=0, out_valid=0.
- Negative floor: inputs -1, -1, -1, -2 -> out_data=0xFFFE (-2). Inputs 1, 1, 1, 2 -> out_data=1.
- Extremes: 0x7FFF×4 -> 0x7FFF. 0x8000×4 -> 0x8000. 0x7FFF, 0x8000, 0x7FFF, 0x8000 -> 0xFFFF.
- Gapped input: samples 4, 8, 12, 16 with in_valid low for 3 cycles between each -> a single output of 10, only after the 4th sample.
- Full/overflow: out_ready=0, feed 9 groups with averages 1..9 -> level=8, overflow=1 after the 9th group. Drain yields 1..8 in order; overflow stays 1.
  - Repeat with out_ready=1 in the 9th group's completion cycle -> no overflow, level stays 8, 9 appears last.
- Reset mid-operation: 2 samples of 100, assert rst one cycle, then 4, 8, 12, 16 -> only output is 10. overflow=0, level=0 immediately after rst.
